// File: rtl/car_light_pkg.sv
// Shared definitions for the multi-channel lamp controller: mode encoding and
// the per-channel mode field accessor.
package car_light_pkg;

  localparam int unsigned MODE_W = 2;
  localparam int unsigned MAX_CH = 32;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_DIM   = 2'b11
  } lamp_mode_e;

  // Mode bus widened to the largest supported channel count so one accessor
  // serves every N_CH.
  typedef logic [MAX_CH*MODE_W-1:0] mode_vec_t;

  function automatic lamp_mode_e ch_mode(input mode_vec_t vec, input int unsigned ch);
    return lamp_mode_e'(vec[ch*MODE_W +: MODE_W]);
  endfunction

endpackage

// File: rtl/car_blink_timer.sv
// Shared blink timer: counts half-periods and toggles the phase. Held at
// cnt=0 / phase=1 while disabled so every fresh blink starts lit.
module car_blink_timer #(
  parameter int unsigned HALF_PERIOD = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic phase
);

  localparam int unsigned CNT_W = $clog2(HALF_PERIOD);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (!enable) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (cnt == CNT_W'(HALF_PERIOD - 1)) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/car_light_ctrl.sv
// Multi-channel lamp controller: per-channel OFF/ON/BLINK/DIM with a shared
// in-phase blink timer, hazard override and a free-running DIM PWM.
module car_light_ctrl
  import car_light_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned HALF_PERIOD = 25000000,
  parameter int unsigned DIM_PERIOD  = 16,
  parameter int unsigned DIM_DUTY    = 4,
  parameter logic [N_CH-1:0] HAZARD_MASK = '1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [MODE_W*N_CH-1:0]   mode,
  input  logic                     hazard,
  output logic [N_CH-1:0]          light,
  output logic                     blink_phase,
  output logic                     blink_tick
);

  localparam int unsigned DIM_W = $clog2(DIM_PERIOD);

  if (N_CH < 1 || N_CH > MAX_CH) begin : g_bad_nch
    $error("car_light_ctrl: N_CH out of range");
  end
  if (HALF_PERIOD < 2) begin : g_bad_hp
    $error("car_light_ctrl: HALF_PERIOD must be >= 2");
  end
  if (DIM_PERIOD < 2 || DIM_DUTY > DIM_PERIOD) begin : g_bad_dim
    $error("car_light_ctrl: bad DIM_PERIOD/DIM_DUTY");
  end

  mode_vec_t          mode_ext;
  lamp_mode_e [N_CH-1:0] eff;
  logic [N_CH-1:0]    is_blink;
  logic [N_CH-1:0]    light_nxt;
  logic               any_blink;
  logic               p;
  logic               dim_on;
  logic               blink_vld_q;
  logic [DIM_W-1:0]   dim_cnt;

  always_comb begin
    mode_ext = '0;
    mode_ext[MODE_W*N_CH-1:0] = mode;
  end

  // Hazard wins over any requested mode on masked channels, same cycle.
  always_comb begin
    eff      = '0;
    is_blink = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      eff[i]      = (hazard && HAZARD_MASK[i]) ? MODE_BLINK : ch_mode(mode_ext, i);
      is_blink[i] = (eff[i] == MODE_BLINK);
    end
  end

  assign any_blink = |is_blink;

  car_blink_timer #(
    .HALF_PERIOD (HALF_PERIOD)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .enable (any_blink),
    .phase  (p)
  );

  always_ff @(posedge clk) begin
    if (rst)
      dim_cnt <= '0;
    else if (dim_cnt == DIM_W'(DIM_PERIOD - 1))
      dim_cnt <= '0;
    else
      dim_cnt <= dim_cnt + 1'b1;
  end

  assign dim_on = (32'(dim_cnt) < DIM_DUTY);

  always_comb begin
    light_nxt = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      case (eff[i])
        MODE_OFF:   light_nxt[i] = 1'b0;
        MODE_ON:    light_nxt[i] = 1'b1;
        MODE_BLINK: light_nxt[i] = p;
        MODE_DIM:   light_nxt[i] = dim_on;
        default:    light_nxt[i] = 1'b0;
      endcase
    end
  end

  // blink_vld_q marks that blink_phase already carried a real phase, so the
  // 0->1 step on blink entry is not reported as a toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      light       <= '0;
      blink_phase <= 1'b0;
      blink_tick  <= 1'b0;
      blink_vld_q <= 1'b0;
    end else begin
      light       <= light_nxt;
      blink_phase <= any_blink & p;
      blink_tick  <= any_blink && (p != blink_phase) && blink_vld_q;
      blink_vld_q <= any_blink;
    end
  end

endmodule
